spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter DATA_W, default 8: frame length in bits, MSB first.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a frame.
REQ-006 data_in  input  DATA_W  word to transmit, captured on accepted start.
REQ-007 busy  output  1  high from the cycle after start acceptance until done.
REQ-008 done  output  1  single-cycle pulse at frame end.
REQ-009 data_out  output  DATA_W  word received on miso in the last frame.
REQ-010 sclk  output  1  serial clock; idles low.
REQ-011 ss  output  1  active-low slave select; idles high.
REQ-012 mosi  output  1  serial data to slave.
REQ-013 miso  input  1  serial data from slave.

Function
REQ-014 Start is accepted only in IDLE with start=1; start while busy is ignored, with no queuing.
REQ-015 On acceptance, the next cycle drives ss=0, busy=1, and mosi=data_in[DATA_W-1]; data_in is loaded into the TX shift register.
REQ-016 States: IDLE -> LEAD -> SCLK_HI <-> SCLK_LO -> [LATCH_HI -> LATCH_LO] -> TRAIL -> IDLE.
REQ-017 LEAD, SCLK_HI, SCLK_LO, LATCH_HI, LATCH_LO and TRAIL each last exactly CLK_DIV cycles.
REQ-018 sclk is 1 in SCLK_HI and LATCH_HI, and 0 in all other states.
REQ-019 The slave shifts on the sclk falling edge, so mosi must be stable across each falling edge.
REQ-020 mosi advances to the next bit exactly one clk cycle after each falling edge; it never changes in the same cycle as a falling edge.
REQ-021 miso is sampled into the RX shift register (shift left, LSB in) in the first cycle of each SCLK_HI.
REQ-022 The bit counter runs 0..DATA_W-1; after the DATA_W-th SCLK_LO the FSM leaves the SCLK_HI/SCLK_LO loop.
REQ-023 Frame length with ss=0, latch pulse off: (2 + 2*DATA_W)*CLK_DIV cycles; 72 cycles at the defaults.
REQ-024 At the end of TRAIL, in the same cycle: ss=1, busy=0, done=1, and data_out = RX shift register.
REQ-025 mosi = 0 whenever ss=1.
REQ-026 data_out holds its value until the next done.
REQ-027 A start asserted in the done cycle is accepted, because the FSM is in IDLE that cycle; back-to-back frames have ss high for at least 1 cycle.

Reset
REQ-028 rst_n low, at any time including mid-frame, immediately forces: state=IDLE, ss=1, sclk=0, mosi=0, busy=0, done=0, data_out=0, counters=0.
REQ-029 After reset release, no frame starts without a new start.

Configuration
REQ-030 Macro SPI_MASTER_LATCH_PULSE_EN: when defined, one extra sclk pulse (LATCH_HI, then LATCH_LO) is inserted after the last data bit, before TRAIL.
REQ-031 During the latch pulse, ss stays 0, mosi=0 and miso is not sampled; the frame is 2*CLK_DIV longer (80 cycles at the defaults).
REQ-032 The latch pulse provides the extra falling edge the team's receiver needs to commit a byte.
REQ-033 When SPI_MASTER_LATCH_PULSE_EN is not defined, the LATCH states do not exist.

Structure
REQ-034 Package spi_pkg holds the FSM state enum and the CLK_DIV and DATA_W default constants, shared with future SPI blocks.
REQ-035 Sub-module spi_clk_div holds the phase counter: it takes enable and CLK_DIV, and outputs a one-cycle tick on the last cycle of each phase.
REQ-036 The FSM advances state only on tick.

Verification
REQ-037 Reset, then start with data_in=8'hA5 and a miso loopback delayed by a half-period -> the mosi sequence 1,0,1,0,0,1,0,1 is stable at every sclk fall, done pulses once, data_out=8'hA5 at done, and ss is low for 72 cycles.
REQ-038 miso tied to 1, data_in=8'h00 -> data_out=8'hFF and mosi=0 throughout.
REQ-039 Start held high for 200 cycles -> frames run back-to-back, ss goes high for at least 1 cycle between frames, and exactly one done per frame.
REQ-040 Start pulsed at cycle 10 of a frame -> ignored, with one done only.
REQ-041 rst_n low at cycle 30 of a frame -> ss=1, sclk=0, busy=0 in the same cycle, and data_out=0.
REQ-042 With SPI_MASTER_LATCH_PULSE_EN defined, drive 8'h3C into a behavioural receiver that commits on its 9th falling edge -> 9 sclk pulses occur, the receiver holds 8'h3C, and ss is low for 80 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame constants.
// LATCH states exist only when SPI_MASTER_LATCH_PULSE_EN is defined.
package spi_pkg;

  localparam int unsigned CLK_DIV_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SCLK_HI,
    ST_SCLK_LO,
`ifdef SPI_MASTER_LATCH_PULSE_EN
    ST_LATCH_HI,
    ST_LATCH_LO,
`endif
    ST_TRAIL
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Phase counter: runs while enabled, flags the first and last cycle
// of every CLK_DIV-long phase.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic first,
  output logic tick
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == 8'(CLK_DIV - 1));
    first = en && (cnt_q == 8'd0);
    cnt_d = 8'd0;
    if (en && !tick) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode with sclk idle low; slave shifts on the falling edge.
// Define SPI_MASTER_LATCH_PULSE_EN to add a trailing latch sclk pulse.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned CNT_W =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SPI_MASTER_LATCH_PULSE_EN
  localparam spi_state_e ST_AFTER = ST_LATCH_HI;
`else
  localparam spi_state_e ST_AFTER = ST_TRAIL;
`endif

  spi_state_e state_q, state_d;

  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic              done_q, done_d;

  logic ph_en, ph_first, ph_tick, last_bit;

  assign ph_en    = (state_q != ST_IDLE);
  assign last_bit = (bit_q == CNT_W'(DATA_W - 1));

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ph_en),
    .first (ph_first),
    .tick  (ph_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start)   state_d = ST_LEAD;
      ST_LEAD:    if (ph_tick) state_d = ST_SCLK_HI;
      ST_SCLK_HI: if (ph_tick) state_d = ST_SCLK_LO;
      ST_SCLK_LO: begin
        if (ph_tick) begin
          state_d = last_bit ? ST_AFTER : ST_SCLK_HI;
        end
      end
`ifdef SPI_MASTER_LATCH_PULSE_EN
      ST_LATCH_HI: if (ph_tick) state_d = ST_LATCH_LO;
      ST_LATCH_LO: if (ph_tick) state_d = ST_TRAIL;
`endif
      ST_TRAIL:   if (ph_tick) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // mosi moves one cycle after the falling edge, i.e. end of LO's first cycle
  always_comb begin
    tx_d   = tx_q;
    rx_d   = rx_q;
    bit_d  = bit_q;
    dout_d = dout_q;
    done_d = 1'b0;
    if (state_q == ST_IDLE && start) begin
      tx_d = data_in;
    end
    if (state_q == ST_LEAD) begin
      bit_d = '0;
    end
    if (state_q == ST_SCLK_HI && ph_first) begin
      rx_d = (rx_q << 1) | DATA_W'(miso);
    end
    if (state_q == ST_SCLK_LO && ph_first) begin
      tx_d = tx_q << 1;
    end
    if (state_q == ST_SCLK_LO && ph_tick && !last_bit) begin
      bit_d = bit_q + CNT_W'(1);
    end
    if (state_q == ST_TRAIL && ph_tick) begin
      done_d = 1'b1;
      dout_d = rx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      rx_q   <= '0;
      dout_q <= '0;
      bit_q  <= '0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      dout_q <= dout_d;
      bit_q  <= bit_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    ss       = (state_q == ST_IDLE);
    busy     = !ss;
    done     = done_q;
    data_out = dout_q;
    sclk     = 1'b0;
    mosi     = 1'b0;
    unique case (state_q)
      ST_LEAD,
      ST_SCLK_LO,
      ST_TRAIL:   mosi = tx_q[DATA_W-1];
      ST_SCLK_HI: begin
        sclk = 1'b1;
        mosi = tx_q[DATA_W-1];
      end
`ifdef SPI_MASTER_LATCH_PULSE_EN
      ST_LATCH_HI: sclk = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master; adapts to SPI_MASTER_LATCH_PULSE_EN.
// A slave model and a bus monitor supply the reference behaviour.
module tb_spi_master;

  localparam int CLK_DIV = 4;
  localparam int W       = 8;
`ifdef SPI_MASTER_LATCH_PULSE_EN
  localparam int NLATCH = 1;
`else
  localparam int NLATCH = 0;
`endif
  localparam int LEN   = (2 + 2 * W + 2 * NLATCH) * CLK_DIV;
  localparam int NFALL = W + NLATCH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         busy, done, sclk, ss, mosi, miso;
  logic [W-1:0] data_out;

  spi_master #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .sclk     (sclk),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic         loop_mode  = 1'b0;
  logic [W-1:0] slave_word = '0;
  logic         slave_bit  = 1'b0;
  logic [7:0]   dl = '0;

  // loopback lags mosi by just under half an sclk period
  always @(posedge clk) dl <= {dl[6:0], mosi};
  assign miso = loop_mode ? dl[CLK_DIV-2] : slave_bit;

  int nfall = 0, last_nfall = 0;
  int ss_len = 0, last_len = 0;
  int hi_run = 0, last_gap = 0;
  int nframes = 0, ndone = 0;
  int unstable = 0, mosi_idle = 0, mosi_hi = 0;
  logic [31:0] fall_bits = '0;
  logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_ss = 1'b1;

  always @(negedge clk) begin
    if (ss) begin
      if (!prev_ss) begin
        last_len   = ss_len;
        last_nfall = nfall;
      end
      ss_len = 0;
      nfall  = 0;
      hi_run++;
      if (mosi !== 1'b0) mosi_idle++;
    end else begin
      if (prev_ss) begin
        nframes++;
        last_gap  = hi_run;
        fall_bits = '0;
        mosi_hi   = 0;
      end
      hi_run = 0;
      ss_len++;
      if (mosi === 1'b1) mosi_hi++;
      if (prev_sclk && !sclk) begin
        if (mosi !== prev_mosi) unstable++;
        fall_bits = {fall_bits[30:0], mosi};
        nfall++;
      end
    end
    if (done) ndone++;
    slave_bit = (nfall < W) ? slave_word[W-1-nfall] : 1'b0;
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_ss   = ss;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < LEN + 10 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    chk({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic frame(input logic [W-1:0] d, input logic [W-1:0] word,
                       input logic loop, input string tag);
    int f0, d0;
    bit got;
    logic [31:0] exp_bits;
    logic [W-1:0] exp_rx;
    @(negedge clk);
    slave_word = word;
    loop_mode  = loop;
    f0 = nframes;
    d0 = ndone;
    data_in = d;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ss"}, 32'(ss), 32'd0);
    chk({tag, "_mosi0"}, 32'(mosi), 32'(d[W-1]));
    got = 1'b0;
    for (int i = 0; i < LEN + 10 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    exp_rx = loop ? d : word;
    if (got) begin
      chk({tag, "_dout"}, 32'(data_out), 32'(exp_rx));
      chk({tag, "_ss_end"}, 32'(ss), 32'd1);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    end
    @(negedge clk);
    exp_bits = 32'(d) << NLATCH;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ndone"}, 32'(ndone - d0), 32'd1);
    chk({tag, "_nframe"}, 32'(nframes - f0), 32'd1);
    chk({tag, "_len"}, 32'(last_len), 32'(LEN));
    chk({tag, "_nfall"}, 32'(last_nfall), 32'(NFALL));
    chk({tag, "_mosi_seq"}, fall_bits, exp_bits);
    chk({tag, "_stable"}, 32'(unstable), 32'd0);
    chk({tag, "_idle_mosi"}, 32'(mosi_idle), 32'd0);
  endtask

  initial begin
    int f0, d0, n0;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    rst_n = 1'b1;
    cyc(5);
    chk("no_auto_start", 32'(busy), 32'd0);

    frame(8'hA5, 8'h00, 1'b1, "a5_loop");

    frame(8'h00, 8'hFF, 1'b0, "ff");
    chk("ff_mosi_zero", 32'(mosi_hi), 32'd0);
    cyc(10);
    chk("dout_hold", 32'(data_out), 32'hFF);

    repeat (4) begin
      frame(W'($urandom), W'($urandom), 1'b0, "rand");
    end

    // start held high: frames back-to-back
    f0 = nframes;
    d0 = ndone;
    @(negedge clk);
    slave_word = W'($urandom);
    data_in = W'($urandom);
    start = 1'b1;
    cyc(200);
    start = 1'b0;
    wait_idle("b2b");
    cyc(2);
    chk("b2b_frames", 32'(nframes - f0), 32'((200 + LEN) / (LEN + 1)));
    chk("b2b_dones", 32'(ndone - d0), 32'((200 + LEN) / (LEN + 1)));
    chk("b2b_gap", 32'(last_gap), 32'd1);

    // start pulse mid-frame is ignored
    f0 = nframes;
    d0 = ndone;
    @(negedge clk);
    slave_word = 8'h5A;
    data_in = 8'h96;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc(9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("mid");
    cyc(3);
    chk("mid_frames", 32'(nframes - f0), 32'd1);
    chk("mid_dones", 32'(ndone - d0), 32'd1);
    chk("mid_dout", 32'(data_out), 32'h5A);

    // reset in the middle of a frame
    @(negedge clk);
    data_in = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc(29);
    rst_n = 1'b0;
    #1;
    chk("mrst_ss", 32'(ss), 32'd1);
    chk("mrst_sclk", 32'(sclk), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_mosi", 32'(mosi), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_dout", 32'(data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = nframes;
    cyc(20);
    chk("mrst_no_frame", 32'(nframes - n0), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);

`ifdef SPI_MASTER_LATCH_PULSE_EN
    // receiver commits the 8 bits seen before its 9th falling edge
    frame(8'h3C, 8'h00, 1'b0, "latch");
    chk("latch_falls", 32'(last_nfall), 32'd9);
    chk("latch_rx", 32'(fall_bits[8:1]), 32'h3C);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
